video_timing_gen: RTL and testbench

Parametrised raster timing generator for the display path. It produces pixel/line counters, a pixel-valid flag, line and frame strobes, and HSYNC/VSYNC. Timing (active, porches, sync widths, polarities) is loadable at run time through shadow registers that take effect only at a frame boundary. A pixel-enable input lets it run from the fast system clock, and a configurable sync delay aligns HSYNC/VSYNC with downstream pixel pipelines.

---
 rtl/video_timing_gen.sv | 175 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, valid and strobe flags, and
// delayed HSYNC/VSYNC, with frame-boundary reload of validated shadow timing.
module video_timing_gen #(
    parameter int unsigned HCNT_W       = 11,
    parameter int unsigned VCNT_W       = 10,
    parameter int unsigned SYNC_DLY     = 1,
    parameter int unsigned DEF_H_ACTIVE = 640,
    parameter int unsigned DEF_H_FP     = 16,
    parameter int unsigned DEF_H_SYNC   = 96,
    parameter int unsigned DEF_H_BP     = 48,
    parameter int unsigned DEF_V_ACTIVE = 480,
    parameter int unsigned DEF_V_FP     = 10,
    parameter int unsigned DEF_V_SYNC   = 2,
    parameter int unsigned DEF_V_BP     = 29,
    parameter int unsigned DEF_HS_POL   = 0,
    parameter int unsigned DEF_VS_POL   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pix_en,
    input  logic              i_cfg_load,
    input  logic [HCNT_W-1:0] i_h_active,
    input  logic [HCNT_W-1:0] i_h_fp,
    input  logic [HCNT_W-1:0] i_h_sync,
    input  logic [HCNT_W-1:0] i_h_bp,
    input  logic [VCNT_W-1:0] i_v_active,
    input  logic [VCNT_W-1:0] i_v_fp,
    input  logic [VCNT_W-1:0] i_v_sync,
    input  logic [VCNT_W-1:0] i_v_bp,
    input  logic              i_hs_pol,
    input  logic              i_vs_pol,
    output logic [HCNT_W-1:0] o_col,
    output logic [VCNT_W-1:0] o_row,
    output logic              o_pix_valid,
    output logic              o_line_start,
    output logic              o_frame_start,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_cfg_pending,
    output logic              o_cfg_err
);

    localparam int unsigned HT_W = HCNT_W + 2;
    localparam int unsigned VT_W = VCNT_W + 2;

    typedef struct packed {
        logic [HCNT_W-1:0] h_active;
        logic [HCNT_W-1:0] h_fp;
        logic [HCNT_W-1:0] h_sync;
        logic [HCNT_W-1:0] h_bp;
        logic [VCNT_W-1:0] v_active;
        logic [VCNT_W-1:0] v_fp;
        logic [VCNT_W-1:0] v_sync;
        logic [VCNT_W-1:0] v_bp;
        logic              hs_pol;
        logic              vs_pol;
    } cfg_t;

    cfg_t def_cfg, in_cfg;
    cfg_t act_q, act_d, shd_q, shd_d;
    logic [HCNT_W-1:0]   col_q, col_d;
    logic [VCNT_W-1:0]   row_q, row_d;
    logic                pend_q, pend_d;
    logic                err_q, err_d;
    logic [SYNC_DLY-1:0] hs_sr_q, hs_sr_d;
    logic [SYNC_DLY-1:0] vs_sr_q, vs_sr_d;

    logic [HT_W-1:0] h_total, in_h_total, h_pos, h_sync_start;
    logic [VT_W-1:0] v_total, in_v_total, v_pos, v_sync_start;
    logic            col_last, row_last, frame_end, load_ok, h_act, v_act;

    assign def_cfg = '{h_active: HCNT_W'(DEF_H_ACTIVE), h_fp: HCNT_W'(DEF_H_FP),
                       h_sync: HCNT_W'(DEF_H_SYNC), h_bp: HCNT_W'(DEF_H_BP),
                       v_active: VCNT_W'(DEF_V_ACTIVE), v_fp: VCNT_W'(DEF_V_FP),
                       v_sync: VCNT_W'(DEF_V_SYNC), v_bp: VCNT_W'(DEF_V_BP),
                       hs_pol: 1'(DEF_HS_POL), vs_pol: 1'(DEF_VS_POL)};

    assign in_cfg = '{h_active: i_h_active, h_fp: i_h_fp, h_sync: i_h_sync, h_bp: i_h_bp,
                      v_active: i_v_active, v_fp: i_v_fp, v_sync: i_v_sync, v_bp: i_v_bp,
                      hs_pol: i_hs_pol, vs_pol: i_vs_pol};

    // Totals are two bits wider than the fields so four-field sums never wrap.
    assign h_total    = HT_W'(act_q.h_active) + HT_W'(act_q.h_fp) + HT_W'(act_q.h_sync) + HT_W'(act_q.h_bp);
    assign v_total    = VT_W'(act_q.v_active) + VT_W'(act_q.v_fp) + VT_W'(act_q.v_sync) + VT_W'(act_q.v_bp);
    assign in_h_total = HT_W'(i_h_active) + HT_W'(i_h_fp) + HT_W'(i_h_sync) + HT_W'(i_h_bp);
    assign in_v_total = VT_W'(i_v_active) + VT_W'(i_v_fp) + VT_W'(i_v_sync) + VT_W'(i_v_bp);

    assign h_pos     = HT_W'(col_q);
    assign v_pos     = VT_W'(row_q);
    assign col_last  = (h_pos == h_total - HT_W'(1));
    assign row_last  = (v_pos == v_total - VT_W'(1));
    assign frame_end = i_pix_en & col_last & row_last;

    assign h_sync_start = HT_W'(act_q.h_active) + HT_W'(act_q.h_fp);
    assign v_sync_start = VT_W'(act_q.v_active) + VT_W'(act_q.v_fp);
    assign h_act = (h_pos >= h_sync_start) && (h_pos < h_sync_start + HT_W'(act_q.h_sync));
    assign v_act = (v_pos >= v_sync_start) && (v_pos < v_sync_start + VT_W'(act_q.v_sync));

    assign load_ok = i_cfg_load
                   && (i_h_active != '0) && (i_h_sync != '0)
                   && (i_v_active != '0) && (i_v_sync != '0)
                   && (in_h_total <= (HT_W'(1) << HCNT_W))
                   && (in_v_total <= (VT_W'(1) << VCNT_W));

    // Raster counters and sync pipelines advance only on pixel ticks.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        hs_sr_d = hs_sr_q;
        vs_sr_d = vs_sr_q;
        if (i_pix_en) begin
            hs_sr_d = SYNC_DLY'({hs_sr_q, h_act});
            vs_sr_d = SYNC_DLY'({vs_sr_q, v_act});
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + VCNT_W'(1);
            end else begin
                col_d = col_q + HCNT_W'(1);
            end
        end
    end

    // Shadow capture and frame-boundary apply; a load on the boundary tick bypasses the shadow.
    always_comb begin
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        err_d  = i_cfg_load & ~load_ok;
        if (load_ok) begin
            shd_d  = in_cfg;
            pend_d = 1'b1;
        end
        if (frame_end) begin
            if (load_ok) begin
                act_d = in_cfg;
            end else if (pend_q) begin
                act_d = shd_q;
            end
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            act_q   <= def_cfg;
            shd_q   <= def_cfg;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            hs_sr_q <= '0;
            vs_sr_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            hs_sr_q <= hs_sr_d;
            vs_sr_q <= vs_sr_d;
        end
    end

    assign o_col         = col_q;
    assign o_row         = row_q;
    assign o_pix_valid   = (col_q < act_q.h_active) && (row_q < act_q.v_active);
    assign o_line_start  = i_pix_en && (col_q == '0);
    assign o_frame_start = i_pix_en && (col_q == '0) && (row_q == '0);
    assign o_hsync       = act_q.hs_pol ? hs_sr_q[SYNC_DLY-1] : ~hs_sr_q[SYNC_DLY-1];
    assign o_vsync       = act_q.vs_pol ? vs_sr_q[SYNC_DLY-1] : ~vs_sr_q[SYNC_DLY-1];
    assign o_cfg_pending = pend_q;
    assign o_cfg_err     = err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a scaled raster (15x8 default, 10x6 reload)
// so whole frames fit in a short run; cycle k counts clocks after reset release.
module tb_video_timing_gen;

    logic       clk, rst, i_pix_en, i_cfg_load;
    logic [5:0] i_h_active, i_h_fp, i_h_sync, i_h_bp;
    logic [4:0] i_v_active, i_v_fp, i_v_sync, i_v_bp;
    logic       i_hs_pol, i_vs_pol;
    logic [5:0] o_col;
    logic [4:0] o_row;
    logic       o_pix_valid, o_line_start, o_frame_start, o_hsync, o_vsync;
    logic       o_cfg_pending, o_cfg_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    video_timing_gen #(
        .HCNT_W(6), .VCNT_W(5), .SYNC_DLY(1),
        .DEF_H_ACTIVE(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(2),
        .DEF_V_ACTIVE(4), .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(1),
        .DEF_HS_POL(0), .DEF_VS_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .i_pix_en(i_pix_en), .i_cfg_load(i_cfg_load),
        .i_h_active(i_h_active), .i_h_fp(i_h_fp), .i_h_sync(i_h_sync), .i_h_bp(i_h_bp),
        .i_v_active(i_v_active), .i_v_fp(i_v_fp), .i_v_sync(i_v_sync), .i_v_bp(i_v_bp),
        .i_hs_pol(i_hs_pol), .i_vs_pol(i_vs_pol),
        .o_col(o_col), .o_row(o_row), .o_pix_valid(o_pix_valid),
        .o_line_start(o_line_start), .o_frame_start(o_frame_start),
        .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_cfg_pending(o_cfg_pending), .o_cfg_err(o_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drive_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
        i_h_active = 6'(ha); i_h_fp = 6'(hf); i_h_sync = 6'(hs); i_h_bp = 6'(hb);
        i_v_active = 5'(va); i_v_fp = 5'(vf); i_v_sync = 5'(vs); i_v_bp = 5'(vb);
        i_hs_pol = hp; i_vs_pol = vp;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) next_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; i_cfg_load = 1'b0; i_pix_en = 1'b1;
        drive_cfg(8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_pix_en = 1'b1; i_cfg_load = 1'b0;
        drive_cfg(8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (o_col !== 6'd0 || o_row !== 5'd0) begin failures++; $display("FAIL rst_counters got col=%0d row=%0d want 0/0", o_col, o_row); end
        checks++; if (o_cfg_pending !== 1'b0 || o_cfg_err !== 1'b0) begin failures++; $display("FAIL rst_cfg got pend=%0b err=%0b want 0/0", o_cfg_pending, o_cfg_err); end
        checks++; if (o_hsync !== 1'b1 || o_vsync !== 1'b1) begin failures++; $display("FAIL rst_sync got hs=%0b vs=%0b want 1/1", o_hsync, o_vsync); end
        @(posedge clk); #1 rst = 1'b0; i_pix_en = 1'b0; cyc = 0;
        #1;
        checks++; if (o_line_start !== 1'b0 || o_frame_start !== 1'b0) begin failures++; $display("FAIL rst_strobe_idle got ls=%0b fs=%0b want 0/0", o_line_start, o_frame_start); end
        checks++; if (o_pix_valid !== 1'b1) begin failures++; $display("FAIL rst_pix_valid got %0b want 1", o_pix_valid); end
        i_pix_en = 1'b1; #1;
        checks++; if (o_line_start !== 1'b1 || o_frame_start !== 1'b1) begin failures++; $display("FAIL rst_strobe_en got ls=%0b fs=%0b want 1/1", o_line_start, o_frame_start); end
        next_cycle(); @(negedge clk);
        checks++; if (o_col !== 6'd1) begin failures++; $display("FAIL rst_first_tick col got %0d want 1", o_col); end
    endtask

    task automatic test_defaults();
        int hs_low = 0, vs_low = 0, first_low = -1;
        do_reset();
        for (int k = 0; k <= 120; k++) begin
            goto_cycle(k); @(negedge clk);
            if (k < 15 && !o_hsync) begin hs_low++; if (first_low < 0) first_low = int'(o_col); end
            if (k < 120 && !o_vsync) vs_low++;
            case (k)
                0:   begin checks++; if (o_frame_start !== 1'b1) begin failures++; $display("FAIL def_fs0 got %0b want 1", o_frame_start); end end
                7:   begin checks++; if (o_pix_valid !== 1'b1) begin failures++; $display("FAIL def_pv_col7 got %0b want 1", o_pix_valid); end end
                8:   begin checks++; if (o_pix_valid !== 1'b0) begin failures++; $display("FAIL def_pv_col8 got %0b want 0", o_pix_valid); end end
                14:  begin checks++; if (o_col !== 6'd14 || o_row !== 5'd0) begin failures++; $display("FAIL def_k14 got col=%0d row=%0d want 14/0", o_col, o_row); end end
                15:  begin checks++; if (o_col !== 6'd0 || o_row !== 5'd1 || o_line_start !== 1'b1 || o_frame_start !== 1'b0) begin failures++; $display("FAIL def_k15 got col=%0d row=%0d ls=%0b fs=%0b want 0/1/1/0", o_col, o_row, o_line_start, o_frame_start); end end
                60:  begin checks++; if (o_pix_valid !== 1'b0) begin failures++; $display("FAIL def_pv_row4 got %0b want 0", o_pix_valid); end end
                75:  begin checks++; if (o_vsync !== 1'b1) begin failures++; $display("FAIL def_vs_k75 got %0b want 1", o_vsync); end end
                76:  begin checks++; if (o_vsync !== 1'b0) begin failures++; $display("FAIL def_vs_k76 got %0b want 0", o_vsync); end end
                119: begin checks++; if (o_col !== 6'd14 || o_row !== 5'd7) begin failures++; $display("FAIL def_k119 got col=%0d row=%0d want 14/7", o_col, o_row); end end
                120: begin checks++; if (o_col !== 6'd0 || o_row !== 5'd0 || o_frame_start !== 1'b1) begin failures++; $display("FAIL def_k120 got col=%0d row=%0d fs=%0b want 0/0/1", o_col, o_row, o_frame_start); end end
                default: ;
            endcase
        end
        checks++; if (hs_low != 3) begin failures++; $display("FAIL def_hs_width got %0d want 3", hs_low); end
        checks++; if (first_low != 11) begin failures++; $display("FAIL def_hs_start got col %0d want 11", first_low); end
        checks++; if (vs_low != 30) begin failures++; $display("FAIL def_vs_width got %0d want 30", vs_low); end
    endtask

    task automatic test_pix_en_half();
        int fs0 = -1, fs1 = -1, hs_low = 0;
        logic [5:0] pcol;
        logic [4:0] prow;
        do_reset();
        pcol = '0; prow = '0;
        for (int c = 0; c < 260; c++) begin
            if (c > 0) next_cycle();
            i_pix_en = (c % 2 == 0);
            @(negedge clk);
            if (o_frame_start) begin if (fs0 < 0) fs0 = c; else if (fs1 < 0) fs1 = c; end
            if (c < 30 && !o_hsync) hs_low++;
            if (c > 0 && c < 40 && c % 2 == 0) begin
                checks++; if (o_col !== pcol || o_row !== prow) begin failures++; $display("FAIL half_hold c=%0d got col=%0d row=%0d want %0d/%0d", c, o_col, o_row, pcol, prow); end
            end
            if (c == 29) begin checks++; if (o_col !== 6'd0 || o_line_start !== 1'b0) begin failures++; $display("FAIL half_c29 got col=%0d ls=%0b want 0/0", o_col, o_line_start); end end
            if (c == 30) begin checks++; if (o_line_start !== 1'b1) begin failures++; $display("FAIL half_c30 ls got %0b want 1", o_line_start); end end
            pcol = o_col; prow = o_row;
        end
        i_pix_en = 1'b1;
        checks++; if (fs0 != 0 || fs1 != 240) begin failures++; $display("FAIL half_frame_period got %0d..%0d want 0..240", fs0, fs1); end
        checks++; if (hs_low != 6) begin failures++; $display("FAIL half_hs_width got %0d want 6", hs_low); end
    endtask

    task automatic test_midframe_load();
        do_reset();
        for (int k = 0; k <= 181; k++) begin
            goto_cycle(k);
            i_cfg_load = 1'b0;
            if (k == 30) begin drive_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1); i_cfg_load = 1'b1; end
            @(negedge clk);
            case (k)
                31:  begin checks++; if (o_cfg_pending !== 1'b1 || o_cfg_err !== 1'b0) begin failures++; $display("FAIL mid_pend got pend=%0b err=%0b want 1/0", o_cfg_pending, o_cfg_err); end end
                119: begin checks++; if (o_cfg_pending !== 1'b1 || o_col !== 6'd14 || o_row !== 5'd7) begin failures++; $display("FAIL mid_k119 got pend=%0b col=%0d row=%0d want 1/14/7", o_cfg_pending, o_col, o_row); end end
                120: begin checks++; if (o_cfg_pending !== 1'b0 || o_col !== 6'd0 || o_row !== 5'd0 || o_hsync !== 1'b0 || o_vsync !== 1'b0) begin failures++; $display("FAIL mid_k120 got pend=%0b col=%0d row=%0d hs=%0b vs=%0b want 0/0/0/0/0", o_cfg_pending, o_col, o_row, o_hsync, o_vsync); end end
                125: begin checks++; if (o_pix_valid !== 1'b1) begin failures++; $display("FAIL mid_pv_col5 got %0b want 1", o_pix_valid); end end
                126: begin checks++; if (o_pix_valid !== 1'b0) begin failures++; $display("FAIL mid_pv_col6 got %0b want 0", o_pix_valid); end end
                127: begin checks++; if (o_hsync !== 1'b0) begin failures++; $display("FAIL mid_hs_col7 got %0b want 0", o_hsync); end end
                128: begin checks++; if (o_hsync !== 1'b1) begin failures++; $display("FAIL mid_hs_col8 got %0b want 1", o_hsync); end end
                129: begin checks++; if (o_hsync !== 1'b1 || o_col !== 6'd9) begin failures++; $display("FAIL mid_k129 got hs=%0b col=%0d want 1/9", o_hsync, o_col); end end
                130: begin checks++; if (o_hsync !== 1'b0 || o_col !== 6'd0 || o_row !== 5'd1) begin failures++; $display("FAIL mid_k130 got hs=%0b col=%0d row=%0d want 0/0/1", o_hsync, o_col, o_row); end end
                160: begin checks++; if (o_vsync !== 1'b0) begin failures++; $display("FAIL mid_vs_k160 got %0b want 0", o_vsync); end end
                161: begin checks++; if (o_vsync !== 1'b1) begin failures++; $display("FAIL mid_vs_k161 got %0b want 1", o_vsync); end end
                170: begin checks++; if (o_vsync !== 1'b1 || o_row !== 5'd5) begin failures++; $display("FAIL mid_k170 got vs=%0b row=%0d want 1/5", o_vsync, o_row); end end
                171: begin checks++; if (o_vsync !== 1'b0) begin failures++; $display("FAIL mid_vs_k171 got %0b want 0", o_vsync); end end
                180: begin checks++; if (o_col !== 6'd0 || o_row !== 5'd0 || o_frame_start !== 1'b1) begin failures++; $display("FAIL mid_k180 got col=%0d row=%0d fs=%0b want 0/0/1", o_col, o_row, o_frame_start); end end
                default: ;
            endcase
        end
    endtask

    task automatic test_reject();
        do_reset();
        for (int k = 0; k <= 184; k++) begin
            goto_cycle(k);
            i_cfg_load = 1'b0;
            case (k)
                5:  begin drive_cfg(8, 2, 0, 2, 4, 1, 2, 1, 1'b1, 1'b1); i_cfg_load = 1'b1; end
                6:  begin drive_cfg(40, 10, 10, 5, 4, 1, 2, 1, 1'b1, 1'b1); i_cfg_load = 1'b1; end
                7:  begin drive_cfg(8, 2, 3, 2, 20, 5, 5, 3, 1'b1, 1'b1); i_cfg_load = 1'b1; end
                8:  begin drive_cfg(8, 2, 3, 2, 0, 1, 2, 1, 1'b1, 1'b1); i_cfg_load = 1'b1; end
                20: begin drive_cfg(40, 10, 10, 4, 20, 5, 4, 3, 1'b0, 1'b0); i_cfg_load = 1'b1; end
                default: ;
            endcase
            @(negedge clk);
            if (k >= 6 && k <= 9) begin
                checks++; if (o_cfg_err !== 1'b1 || o_cfg_pending !== 1'b0) begin failures++; $display("FAIL rej_err k=%0d got err=%0b pend=%0b want 1/0", k, o_cfg_err, o_cfg_pending); end
            end
            case (k)
                10:  begin checks++; if (o_cfg_err !== 1'b0 || o_cfg_pending !== 1'b0) begin failures++; $display("FAIL rej_k10 got err=%0b pend=%0b want 0/0", o_cfg_err, o_cfg_pending); end end
                21:  begin checks++; if (o_cfg_pending !== 1'b1 || o_cfg_err !== 1'b0) begin failures++; $display("FAIL rej_max_accept got pend=%0b err=%0b want 1/0", o_cfg_pending, o_cfg_err); end end
                119: begin checks++; if (o_col !== 6'd14 || o_row !== 5'd7) begin failures++; $display("FAIL rej_k119 got col=%0d row=%0d want 14/7", o_col, o_row); end end
                120: begin checks++; if (o_col !== 6'd0 || o_row !== 5'd0 || o_cfg_pending !== 1'b0) begin failures++; $display("FAIL rej_k120 got col=%0d row=%0d pend=%0b want 0/0/0", o_col, o_row, o_cfg_pending); end end
                183: begin checks++; if (o_col !== 6'd63 || o_row !== 5'd0) begin failures++; $display("FAIL rej_k183 got col=%0d row=%0d want 63/0", o_col, o_row); end end
                184: begin checks++; if (o_col !== 6'd0 || o_row !== 5'd1) begin failures++; $display("FAIL rej_k184 got col=%0d row=%0d want 0/1", o_col, o_row); end end
                default: ;
            endcase
        end
    endtask

    task automatic test_frame_end_load();
        do_reset();
        for (int k = 0; k <= 180; k++) begin
            goto_cycle(k);
            i_cfg_load = 1'b0;
            if (k == 119) begin drive_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0); i_cfg_load = 1'b1; end
            @(negedge clk);
            case (k)
                119: begin checks++; if (o_col !== 6'd14 || o_row !== 5'd7 || o_cfg_pending !== 1'b0) begin failures++; $display("FAIL fe_k119 got col=%0d row=%0d pend=%0b want 14/7/0", o_col, o_row, o_cfg_pending); end end
                120: begin checks++; if (o_col !== 6'd0 || o_row !== 5'd0 || o_cfg_pending !== 1'b0 || o_cfg_err !== 1'b0) begin failures++; $display("FAIL fe_k120 got col=%0d row=%0d pend=%0b err=%0b want 0/0/0/0", o_col, o_row, o_cfg_pending, o_cfg_err); end end
                125: begin checks++; if (o_cfg_pending !== 1'b0) begin failures++; $display("FAIL fe_pend_k125 got %0b want 0", o_cfg_pending); end end
                129: begin checks++; if (o_col !== 6'd9 || o_row !== 5'd0) begin failures++; $display("FAIL fe_k129 got col=%0d row=%0d want 9/0", o_col, o_row); end end
                130: begin checks++; if (o_col !== 6'd0 || o_row !== 5'd1) begin failures++; $display("FAIL fe_k130 got col=%0d row=%0d want 0/1", o_col, o_row); end end
                179: begin checks++; if (o_col !== 6'd9 || o_row !== 5'd5) begin failures++; $display("FAIL fe_k179 got col=%0d row=%0d want 9/5", o_col, o_row); end end
                180: begin checks++; if (o_col !== 6'd0 || o_row !== 5'd0 || o_frame_start !== 1'b1) begin failures++; $display("FAIL fe_k180 got col=%0d row=%0d fs=%0b want 0/0/1", o_col, o_row, o_frame_start); end end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k <= 80; k++) begin
            goto_cycle(k);
            i_cfg_load = 1'b0;
            if (k == 3) begin drive_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1); i_cfg_load = 1'b1; end
            @(negedge clk);
            if (k == 4) begin checks++; if (o_cfg_pending !== 1'b1) begin failures++; $display("FAIL rm_pend got %0b want 1", o_cfg_pending); end end
            if (k == 80) begin checks++; if (o_vsync !== 1'b0 || o_col !== 6'd5 || o_row !== 5'd5) begin failures++; $display("FAIL rm_pre got vs=%0b col=%0d row=%0d want 0/5/5", o_vsync, o_col, o_row); end end
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; cyc = 0;
        @(negedge clk);
        checks++; if (o_col !== 6'd0 || o_row !== 5'd0 || o_cfg_pending !== 1'b0 || o_cfg_err !== 1'b0) begin failures++; $display("FAIL rm_state got col=%0d row=%0d pend=%0b err=%0b want 0/0/0/0", o_col, o_row, o_cfg_pending, o_cfg_err); end
        checks++; if (o_hsync !== 1'b1 || o_vsync !== 1'b1) begin failures++; $display("FAIL rm_sync got hs=%0b vs=%0b want 1/1", o_hsync, o_vsync); end
        goto_cycle(10); @(negedge clk);
        checks++; if (o_col !== 6'd10) begin failures++; $display("FAIL rm_def_col got %0d want 10", o_col); end
        goto_cycle(11); @(negedge clk);
        checks++; if (o_hsync !== 1'b0) begin failures++; $display("FAIL rm_def_hs_pol got %0b want 0", o_hsync); end
        goto_cycle(15); @(negedge clk);
        checks++; if (o_col !== 6'd0 || o_row !== 5'd1) begin failures++; $display("FAIL rm_def_wrap got col=%0d row=%0d want 0/1", o_col, o_row); end
    endtask

    initial begin
        rst = 1'b1; i_pix_en = 1'b0; i_cfg_load = 1'b0;
        drive_cfg(8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0);
        test_reset();
        test_defaults();
        test_pix_en_half();
        test_midframe_load();
        test_reject();
        test_frame_end_load();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
